// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C byte-transaction master among NREQ requesters,
// with a saturating watchdog that aborts transactions the master never completes.
module i2c_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int ASIZE   = 7,
  parameter int DSIZE   = 8,
  parameter int TIMEOUT = 200000
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_rw,
  input  logic [NREQ*ASIZE-1:0] req_dev,
  input  logic [NREQ*8-1:0]     req_reg,
  input  logic [NREQ*DSIZE-1:0] req_wdata,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [DSIZE-1:0]      rsp_rdata,
  output logic [1:0]            rsp_err,
  output logic                  m_start,
  output logic                  m_rw,
  output logic [ASIZE-1:0]      m_dev,
  output logic [7:0]            m_reg,
  output logic [DSIZE-1:0]      m_wdata,
  output logic                  m_abort,
  input  logic                  m_done,
  input  logic                  m_nack,
  input  logic [DSIZE-1:0]      m_rdata,
  output logic                  busy
);

  localparam int PW = $clog2(NREQ);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [WW-1:0]   WD_LAST  = WW'(TIMEOUT - 1);
  localparam logic [PW-1:0]   LAST_REQ = PW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]    gnt_q, gnt_d;
  logic [WW-1:0]    wd_q, wd_d;
  logic             m_rw_q, m_rw_d;
  logic [ASIZE-1:0] m_dev_q, m_dev_d;
  logic [7:0]       m_reg_q, m_reg_d;
  logic [DSIZE-1:0] m_wdata_q, m_wdata_d;
  logic [DSIZE-1:0] rdata_q, rdata_d;
  logic [1:0]       err_q, err_d;

  logic             any_req;
  logic [PW-1:0]    pick;
  logic [PW:0]      cand;
  logic             sel_rw;
  logic [ASIZE-1:0] sel_dev;
  logic [7:0]       sel_reg;
  logic [DSIZE-1:0] sel_wdata;
  logic             wd_expired;

  // First pending requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    any_req = 1'b0;
    pick    = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (PW+1)'(i);
      if (cand >= (PW+1)'(NREQ)) cand = cand - (PW+1)'(NREQ);
      if (!any_req && req_valid[cand[PW-1:0]]) begin
        any_req = 1'b1;
        pick    = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    sel_rw    = 1'b0;
    sel_dev   = '0;
    sel_reg   = '0;
    sel_wdata = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (pick == PW'(j)) begin
        sel_rw    = req_rw[j];
        sel_dev   = req_dev[j*ASIZE +: ASIZE];
        sel_reg   = req_reg[j*8 +: 8];
        sel_wdata = req_wdata[j*DSIZE +: DSIZE];
      end
    end
  end

  assign wd_expired = (wd_q == WD_LAST);

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      gnt_q     <= '0;
      wd_q      <= '0;
      m_rw_q    <= 1'b0;
      m_dev_q   <= '0;
      m_reg_q   <= '0;
      m_wdata_q <= '0;
      rdata_q   <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_q     <= gnt_d;
      wd_q      <= wd_d;
      m_rw_q    <= m_rw_d;
      m_dev_q   <= m_dev_d;
      m_reg_q   <= m_reg_d;
      m_wdata_q <= m_wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = gnt_q;
    wd_d      = wd_q;
    m_rw_d    = m_rw_q;
    m_dev_d   = m_dev_q;
    m_reg_d   = m_reg_q;
    m_wdata_d = m_wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          gnt_d     = pick;
          m_rw_d    = sel_rw;
          m_dev_d   = sel_dev;
          m_reg_d   = sel_reg;
          m_wdata_d = sel_wdata;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_d = (&wd_q) ? wd_q : wd_q + 1'b1;
        // Completion takes priority over a watchdog expiry in the same cycle.
        if (m_done) begin
          rdata_d = (m_rw_q && !m_nack) ? m_rdata : '0;
          err_d   = m_nack ? 2'b01 : 2'b00;
          state_d = S_RESP;
        end else if (wd_expired) begin
          rdata_d = '0;
          err_d   = 2'b10;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rr_ptr_d = (gnt_q == LAST_REQ) ? '0 : gnt_q + 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    m_start   = 1'b0;
    m_abort   = 1'b0;
    if (!rst) begin
      if (state_q == S_IDLE && any_req) req_ready = ONE_HOT0 << pick;
      if (state_q == S_RESP)            rsp_valid = ONE_HOT0 << gnt_q;
      m_start = (state_q == S_ISSUE);
      m_abort = (state_q == S_WAIT) && !m_done && wd_expired;
    end
    busy      = (state_q != S_IDLE);
    m_rw      = m_rw_q;
    m_dev     = m_dev_q;
    m_reg     = m_reg_q;
    m_wdata   = m_wdata_q;
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
  end

endmodule
